// File: rtl/hamm_decode_sched.sv
// hamm_decode_sched: one Hamming(7,4) SEC decoder shared by NREQ requesters
// through a round-robin arbiter. Results leave on a valid/ready port with the
// source index attached.
// Optional macro HAMM_SCHED_STATS_EN: enables the saturating err_count
// counter. Without it, err_count is tied to zero.
module hamm_decode_sched #(
  parameter int NREQ  = 4,
  parameter int SRC_W = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [7*NREQ-1:0]    cw_in,
  output logic [NREQ-1:0]      ack,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3:0]           out_data,
  output logic [SRC_W-1:0]     out_src,
  output logic                 out_err,
  output logic [2:0]           out_syn,
  output logic                 busy,
  output logic [15:0]          err_count
);

  typedef enum logic [1:0] {S_IDLE, S_SYND, S_CORR, S_OUT} state_t;

  state_t             state_q, state_d;
  logic [SRC_W-1:0]   last_q, src_q, grant;
  logic [6:0]         cw_q, cw_sel, cw_fix, flip;
  logic [2:0]         syn_q, syn_d;
  logic [NREQ-1:0]    ack_q, ack_d;
  logic               any_req, hit_hi, hit_lo;
  logic [SRC_W-1:0]   g_hi, g_lo;
  logic [3:0]         out_data_q;
  logic [SRC_W-1:0]   out_src_q;
  logic               out_err_q;
  logic [2:0]         out_syn_q;

  // Round-robin pick: lowest requester above last wins, else wrap to the
  // lowest at or below last. Equivalent to scanning last+1, last+2, ... mod NREQ.
  always_comb begin
    hit_hi = 1'b0;
    hit_lo = 1'b0;
    g_hi   = '0;
    g_lo   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (req[k] && (k > 32'(last_q)) && !hit_hi) begin
        hit_hi = 1'b1;
        g_hi   = SRC_W'(k);
      end
      if (req[k] && (k <= 32'(last_q)) && !hit_lo) begin
        hit_lo = 1'b1;
        g_lo   = SRC_W'(k);
      end
    end
    any_req = hit_hi | hit_lo;
    grant   = hit_hi ? g_hi : g_lo;
    cw_sel  = '0;
    ack_d   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (SRC_W'(k) == grant) cw_sel = cw_in[7*k +: 7];
      ack_d[k] = any_req && (SRC_W'(k) == grant);
    end
  end

  // Syndrome of the captured word and single-bit correction (syn=p flips bit 7-p).
  always_comb begin
    syn_d = {cw_q[3] ^ cw_q[2] ^ cw_q[1] ^ cw_q[0],
             cw_q[5] ^ cw_q[4] ^ cw_q[1] ^ cw_q[0],
             cw_q[6] ^ cw_q[4] ^ cw_q[2] ^ cw_q[0]};
    flip  = '0;
    if (syn_q != 3'd0) flip = 7'(1) << (3'd7 - syn_q);
    cw_fix = cw_q ^ flip;
  end

  // Next-state logic and state-derived outputs.
  always_comb begin
    state_d   = state_q;
    out_valid = (state_q == S_OUT);
    busy      = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE:  if (any_req) state_d = S_SYND;
      S_SYND:  state_d = S_CORR;
      S_CORR:  state_d = S_OUT;
      S_OUT:   if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Capture, syndrome and result registers, each loaded in its own stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q     <= SRC_W'(NREQ - 1);
      src_q      <= '0;
      cw_q       <= '0;
      syn_q      <= '0;
      ack_q      <= '0;
      out_data_q <= '0;
      out_src_q  <= '0;
      out_err_q  <= 1'b0;
      out_syn_q  <= '0;
    end else begin
      ack_q <= (state_q == S_IDLE) ? ack_d : '0;
      if (state_q == S_IDLE && any_req) begin
        cw_q   <= cw_sel;
        src_q  <= grant;
        last_q <= grant;
      end
      if (state_q == S_SYND) syn_q <= syn_d;
      if (state_q == S_CORR) begin
        out_data_q <= {cw_fix[4], cw_fix[2], cw_fix[1], cw_fix[0]};
        out_src_q  <= src_q;
        out_err_q  <= (syn_q != 3'd0);
        out_syn_q  <= syn_q;
      end
    end
  end

  assign ack      = ack_q;
  assign out_data = out_data_q;
  assign out_src  = out_src_q;
  assign out_err  = out_err_q;
  assign out_syn  = out_syn_q;

`ifdef HAMM_SCHED_STATS_EN
  logic [15:0] err_cnt_q;

  // Count corrected words on the CORR->OUT edge, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (state_q == S_CORR && syn_q != 3'd0 && err_cnt_q != '1) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_hamm_decode_sched.sv
// Bench for hamm_decode_sched: transaction-level model (brute-force Hamming
// decode, round-robin pick, cycle countdown) checked every cycle, plus directed
// scenarios with hand-computed expectations.
module tb_hamm_decode_sched;
  localparam int NREQ  = 4;
  localparam int SRC_W = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req;
  logic [7*NREQ-1:0]   cw_in;
  logic [NREQ-1:0]     ack;
  logic                out_valid;
  logic                out_ready;
  logic [3:0]          out_data;
  logic [SRC_W-1:0]    out_src;
  logic                out_err;
  logic [2:0]          out_syn;
  logic                busy;
  logic [15:0]         err_count;

  hamm_decode_sched #(.NREQ(NREQ), .SRC_W(SRC_W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .cw_in(cw_in), .ack(ack),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_src(out_src), .out_err(out_err), .out_syn(out_syn), .busy(busy),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit chk_on = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: no response within bound (cycle %0d)", name, cyc);
  endtask

  // Encode by Hamming position rules: position p lives at bit 7-p, parity at 1,2,4.
  function automatic logic [6:0] enc(input logic [3:0] d);
    logic [6:0] c;
    logic       p;
    c    = '0;
    c[4] = d[3];
    c[2] = d[2];
    c[1] = d[1];
    c[0] = d[0];
    for (int k = 0; k < 3; k++) begin
      p = 1'b0;
      for (int pos = 1; pos <= 7; pos++)
        if (((pos >> k) & 1) == 1 && pos != (1 << k)) p = p ^ c[3'(7 - pos)];
      c[3'(7 - (1 << k))] = p;
    end
    return c;
  endfunction

  // Nearest-codeword search; returns {err, syn, data}.
  function automatic logic [7:0] dec(input logic [6:0] cw);
    logic [6:0] diff;
    for (int d = 0; d < 16; d++) begin
      diff = enc(4'(d)) ^ cw;
      if (diff == 7'd0) return {1'b0, 3'd0, 4'(d)};
      if ($countones(diff) == 1)
        for (int b = 0; b < 7; b++)
          if (diff[b]) return {1'b1, 3'(7 - b), 4'(d)};
    end
    return 8'h00;
  endfunction

  function automatic int pick(input logic [NREQ-1:0] r, input int last);
    int i;
    for (int k = 1; k <= NREQ; k++) begin
      i = (last + k) % NREQ;
      if (r[i]) return i;
    end
    return 0;
  endfunction

  // Model: m_cnt counts cycles since capture (0 = free, 3 = result offered).
  int         m_cnt = 0;
  int         m_last = NREQ - 1;
  int         m_src = 0;
  int         m_errs = 0;
  logic [7:0] m_exp = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_cnt  = 0;
      m_last = NREQ - 1;
      m_errs = 0;
    end else begin
      case (m_cnt)
        0: if (|req) begin
             m_src  = pick(req, m_last);
             m_last = m_src;
             m_exp  = dec(cw_in[7*m_src +: 7]);
             m_cnt  = 1;
           end
        1: m_cnt = 2;
        2: begin
             m_cnt = 3;
             if (m_exp[7] && m_errs < 65535) m_errs++;
           end
        default: if (out_ready) m_cnt = 0;
      endcase
    end
  end

  function automatic int exp_errs();
`ifdef HAMM_SCHED_STATS_EN
    return m_errs;
`else
    return 0;
`endif
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("ack", 32'(ack), (m_cnt == 1) ? (32'd1 << m_src) : 32'd0);
      chk("out_valid", 32'(out_valid), 32'(m_cnt == 3));
      chk("busy", 32'(busy), 32'(m_cnt != 0));
      chk("err_count", 32'(err_count), 32'(exp_errs()));
      if (m_cnt == 3) begin
        chk("out_data", 32'(out_data), 32'(m_exp[3:0]));
        chk("out_src", 32'(out_src), 32'(m_src));
        chk("out_err", 32'(out_err), 32'(m_exp[7]));
        chk("out_syn", 32'(out_syn), 32'(m_exp[6:4]));
      end
    end
  end

  task automatic wait_ack(output int idx, output int at);
    idx = -1;
    at  = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (ack != '0) begin
        for (int k = 0; k < NREQ; k++) if (ack[k]) idx = k;
        at = cyc;
        break;
      end
    end
    if (idx < 0) timeout_fail("ack_wait");
  endtask

  task automatic wait_valid(output int at);
    at = -1;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (out_valid) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) timeout_fail("valid_wait");
  endtask

  task automatic run_one(input int idx, input logic [6:0] cw,
                         output logic [7:0] res, output int src);
    int a, t0, t1;
    cw_in[7*idx +: 7] = cw;
    req = NREQ'(1) << idx;
    wait_ack(a, t0);
    req = '0;
    chk("ack_index", 32'(a), 32'(idx));
    wait_valid(t1);
    chk("latency", 32'(t1 - t0), 32'd2);
    res = {out_err, out_syn, out_data};
    src = int'(out_src);
  endtask

  task automatic rst_pulse();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] r;
    int         s, a, t;
    int         ord[5];
    int         tim[5];
    int         exp_ord[5];
    logic [3:0] held;

    exp_ord   = '{0, 1, 2, 3, 0};
    rst_n     = 1'b0;
    req       = '1;
    cw_in     = '0;
    out_ready = 1'b1;

    // T1: reset held two cycles with every request active
    @(posedge clk);
    #1 chk_on = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_errcnt", 32'(err_count), 32'd0);
    chk("model_enc_1011", 32'(enc(4'b1011)), 32'h33);
    rst_n = 1'b1;
    req   = '0;

    // T2: clean all-zero word from requester 0
    run_one(0, 7'b0000000, r, s);
    chk("t2_data", 32'(r[3:0]), 32'd0);
    chk("t2_err", 32'(r[7]), 32'd0);
    chk("t2_syn", 32'(r[6:4]), 32'd0);
    chk("t2_src", 32'(s), 32'd0);

    // T3: codeword of 1011 with bit 4 flipped, from requester 1
    run_one(1, 7'b0100011, r, s);
    chk("t3_data", 32'(r[3:0]), 32'hB);
    chk("t3_err", 32'(r[7]), 32'd1);
    chk("t3_syn", 32'(r[6:4]), 32'd3);
    chk("t3_src", 32'(s), 32'd1);

    // T4: all requesters held high from a fresh pointer
    rst_pulse();
    cw_in = {7'b1000000, 7'b0110011, 7'b0000001, 7'b1111111};
    req   = '1;
    for (int n = 0; n < 5; n++) wait_ack(ord[n], tim[n]);
    req = '0;
    for (int n = 0; n < 5; n++) begin
      chk("rr_order", 32'(ord[n]), 32'(exp_ord[n]));
      if (n > 0) chk("rr_spacing", 32'(tim[n] - tim[n-1]), 32'd4);
    end
    repeat (6) @(negedge clk);

    // T5: backpressure holds the result; a pending request is not granted
    out_ready = 1'b0;
    run_one(2, 7'b0000100, r, s);
    chk("t5_syn", 32'(r[6:4]), 32'd5);
    held = r[3:0];
    cw_in[21 +: 7] = 7'b1111111;
    req = 4'b1000;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_data", 32'(out_data), 32'(held));
      chk("bp_ack", 32'(ack), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_busy", 32'(busy), 32'd0);
    wait_ack(a, t);
    req = '0;
    chk("bp_next_ack", 32'(a), 32'd3);
    wait_valid(t);
    chk("bp_next_data", 32'(out_data), 32'hF);

    // T6: three corrected and two clean words
    @(negedge clk);
    rst_pulse();
    run_one(0, 7'b0000001, r, s);
    run_one(1, 7'b0000000, r, s);
    run_one(2, 7'b1000000, r, s);
    run_one(3, 7'b1111111, r, s);
    run_one(0, 7'b0100011, r, s);
    repeat (3) @(negedge clk);
`ifdef HAMM_SCHED_STATS_EN
    chk("stats_count", 32'(err_count), 32'd3);
`else
    chk("stats_count", 32'(err_count), 32'd0);
`endif

    // Reset while in SYND: result dropped, pointer back to NREQ-1
    cw_in[14 +: 7] = 7'b0100011;
    req = 4'b0100;
    wait_ack(a, t);
    rst_n = 1'b0;
    req   = '0;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("midrst_no_valid", 32'(out_valid), 32'd0);
    end
    req = '1;
    wait_ack(a, t);
    req = '0;
    chk("midrst_first_grant", 32'(a), 32'd0);
    repeat (6) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
